// File: rtl/axi_sram_scheduler.sv
// Single-outstanding AXI master shared by the fetch and data requesters.
// Round-robin grant, single-beat 32-bit transfers, one-cycle done pulse per requester.
module axi_sram_scheduler #(
  parameter int         ADDR_W  = 32,
  parameter int         DATA_W  = 32,
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1,
  localparam int        STRB_W  = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [DATA_W-1:0] inst_rdata_o,
  output logic              inst_done_o,
  input  logic              data_req_i,
  input  logic [STRB_W-1:0] data_we_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_done_o,
  output logic [3:0]        arid_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  output logic [3:0]        arlen_o,
  output logic [2:0]        arsize_o,
  output logic [1:0]        arburst_o,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              rlast_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic [3:0]        awid_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [3:0]        awlen_o,
  output logic [2:0]        awsize_o,
  output logic [1:0]        awburst_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [STRB_W-1:0] wstrb_o,
  output logic              wlast_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic              bvalid_i,
  output logic              bready_o
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

  // Requester encoding for owner and last_grant: 0 = instruction, 1 = data.
  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [STRB_W-1:0] we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              aw_ok_q, aw_ok_d;
  logic              w_ok_q, w_ok_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              grant_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      we_q         <= '0;
      wdata_q      <= '0;
      aw_ok_q      <= 1'b0;
      w_ok_q       <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      aw_ok_q      <= aw_ok_d;
      w_ok_q       <= w_ok_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    aw_ok_d      = aw_ok_q;
    w_ok_d       = w_ok_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    grant_data   = 1'b0;
    arvalid_o    = 1'b0;
    rready_o     = 1'b0;
    awvalid_o    = 1'b0;
    wvalid_o     = 1'b0;
    bready_o     = 1'b0;
    inst_done_o  = 1'b0;
    data_done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (inst_req_i || data_req_i) begin
          // With both pending, data wins only if instruction had the previous grant.
          grant_data   = data_req_i && (!inst_req_i || !last_grant_q);
          owner_d      = grant_data;
          last_grant_d = grant_data;
          addr_d       = grant_data ? data_addr_i : inst_addr_i;
          we_d         = grant_data ? data_we_i : '0;
          wdata_d      = data_wdata_i;
          aw_ok_d      = 1'b0;
          w_ok_d       = 1'b0;
          state_d      = (grant_data && (data_we_i != '0)) ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        arvalid_o = 1'b1;
        if (arready_i) state_d = RD_DATA;
      end
      RD_DATA: begin
        rready_o = 1'b1;
        if (rvalid_i) begin
          if (owner_q) data_rdata_d = rdata_i;
          else         inst_rdata_d = rdata_i;
          state_d = DONE;
        end
      end
      WR_REQ: begin
        awvalid_o = !aw_ok_q;
        wvalid_o  = !w_ok_q;
        if (awvalid_o && awready_i) aw_ok_d = 1'b1;
        if (wvalid_o && wready_i)   w_ok_d  = 1'b1;
        if (aw_ok_d && w_ok_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        bready_o = 1'b1;
        if (bvalid_i) state_d = DONE;
      end
      DONE: begin
        inst_done_o = !owner_q;
        data_done_o = owner_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign arid_o       = owner_q ? DATA_ID : INST_ID;
  assign awid_o       = owner_q ? DATA_ID : INST_ID;
  assign araddr_o     = addr_q;
  assign awaddr_o     = addr_q;
  assign arlen_o      = 4'd0;
  assign arsize_o     = 3'b010;
  assign arburst_o    = 2'b01;
  assign awlen_o      = 4'd0;
  assign awsize_o     = 3'b010;
  assign awburst_o    = 2'b01;
  assign wdata_o      = wdata_q;
  assign wstrb_o      = we_q;
  assign wlast_o      = 1'b1;
  assign inst_rdata_o = inst_rdata_q;
  assign data_rdata_o = data_rdata_q;

  // Every transfer is single-beat, so rlast carries no information.
  logic unused_rlast;
  assign unused_rlast = rlast_i;

endmodule

// File: tb/tb_axi_sram_scheduler.sv
// Bench for axi_sram_scheduler: AXI slave model with programmable delays,
// table-driven single transactions, hand sequences for arbitration/reset/latching.
module tb_axi_sram_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_req, data_req;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_we;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_done, data_done;
  logic [3:0]  arid, awid, arlen, awlen;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  axi_sram_scheduler dut (
    .clk_i(clk), .rst_ni(rst_n),
    .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_rdata_o(inst_rdata), .inst_done_o(inst_done),
    .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_rdata_o(data_rdata), .data_done_o(data_done),
    .arid_o(arid), .araddr_o(araddr), .arvalid_o(arvalid), .arready_i(arready),
    .arlen_o(arlen), .arsize_o(arsize), .arburst_o(arburst),
    .rdata_i(rdata), .rlast_i(rlast), .rvalid_i(rvalid), .rready_o(rready),
    .awid_o(awid), .awaddr_o(awaddr), .awvalid_o(awvalid), .awready_i(awready),
    .awlen_o(awlen), .awsize_o(awsize), .awburst_o(awburst),
    .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast), .wvalid_o(wvalid), .wready_i(wready),
    .bvalid_i(bvalid), .bready_o(bready)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int          cfg_ar = 0, cfg_r = 0, cfg_aw = 0, cfg_w = 0, cfg_b = 0;
  bit          cfg_fixed = 1'b1;
  logic [31:0] cfg_rdata = '0;
  logic [31:0] obs_araddr, obs_awaddr, obs_wdata;
  logic [3:0]  obs_arid, obs_awid, obs_wstrb;
  logic        obs_wlast;
  int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int          aw_hi = 0, w_hi = 0, both_hi = 0, ar_unstable = 0;

  initial begin
    arready = 0; rvalid = 0; rdata = '0; rlast = 1; awready = 0; wready = 0; bvalid = 0;
    forever begin
      @(negedge clk);
      if (arvalid && awvalid) both_hi++;
      if (arvalid) begin
        if (ar_cnt == 0) begin obs_araddr = araddr; obs_arid = arid; end
        else if (araddr !== obs_araddr || arid !== obs_arid) ar_unstable++;
        arready = (ar_cnt >= cfg_ar); ar_cnt++;
      end else begin arready = 0; ar_cnt = 0; end
      if (rready) begin
        rvalid = (r_cnt >= cfg_r); r_cnt++;
        rdata = !rvalid ? 32'hDEADBEEF : (cfg_fixed ? cfg_rdata : (obs_araddr ^ 32'h5A5A5A5A));
      end else begin rvalid = 0; r_cnt = 0; rdata = 32'hDEADBEEF; end
      if (awvalid) begin
        if (aw_cnt == 0) begin obs_awaddr = awaddr; obs_awid = awid; end
        aw_hi++; awready = (aw_cnt >= cfg_aw); aw_cnt++;
      end else begin awready = 0; aw_cnt = 0; end
      if (wvalid) begin
        if (w_cnt == 0) begin obs_wdata = wdata; obs_wstrb = wstrb; obs_wlast = wlast; end
        w_hi++; wready = (w_cnt >= cfg_w); w_cnt++;
      end else begin wready = 0; w_cnt = 0; end
      if (bready) begin bvalid = (b_cnt >= cfg_b); b_cnt++; end
      else begin bvalid = 0; b_cnt = 0; end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          owner;
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  strb;
  } exp_t;
  exp_t sb[$];

  task automatic push(input bit owner, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] rd, input logic [3:0] strb);
    exp_t e;
    e.owner = owner; e.is_wr = wr; e.addr = addr; e.wdata = wd; e.rdata = rd; e.strb = strb;
    sb.push_back(e);
  endtask

  task automatic check_done(input logic [31:0] pi, input logic [31:0] pd);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL sb_empty: got done with no expected transaction");
      return;
    end
    e = sb.pop_front();
    chk("data_done", data_done, e.owner);
    chk("inst_done", inst_done, !e.owner);
    if (!e.is_wr) begin
      chk("araddr", obs_araddr, e.addr);
      chk("arid", obs_arid, e.owner ? 4'd1 : 4'd0);
      chk(e.owner ? "data_rdata" : "inst_rdata", e.owner ? data_rdata : inst_rdata, e.rdata);
      chk("other_rdata_hold", e.owner ? inst_rdata : data_rdata, e.owner ? pi : pd);
    end else begin
      chk("awaddr", obs_awaddr, e.addr);
      chk("awid", obs_awid, 4'd1);
      chk("wdata", obs_wdata, e.wdata);
      chk("wstrb", obs_wstrb, e.strb);
      chk("wlast", obs_wlast, 1'b1);
      chk("wr_rdata_hold", {inst_rdata ^ pi} | {data_rdata ^ pd}, 32'h0);
    end
  endtask

  task automatic wait_done(output int lat);
    logic [31:0] pi, pd;
    bit          early;
    pi = inst_rdata; pd = data_rdata; early = 0; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!(inst_done || data_done) && (inst_rdata !== pi || data_rdata !== pd)) early = 1;
    end while (!(inst_done || data_done) && lat < 200);
    if (!(inst_done || data_done)) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: got no done in %0d cycles expected a done pulse", lat);
      return;
    end
    chk("rdata_before_done", early, 1'b0);
    check_done(pi, pd);
  endtask

  // ---------------- single-transaction table ----------------
  typedef struct {
    bit          is_data;
    logic [3:0]  we;
    logic [31:0] addr, wdata, rdata;
    int          ar_d, r_d, aw_d, w_d, b_d;
    int          lat, exp_aw_hi, exp_w_hi;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    inst_req = 0; data_req = 0; inst_addr = '0; data_addr = '0; data_wdata = '0; data_we = '0;
    rst_n = 0;

    vecs[0] = '{0, 4'b0000, 32'hBFC00000, 32'h0,        32'h3C08BFC0, 0, 0, 0, 0, 0, 3,  0, 0};
    vecs[1] = '{1, 4'b0011, 32'h80000010, 32'h1234ABCD, 32'h0,        0, 0, 3, 0, 0, 6,  4, 1};
    vecs[2] = '{1, 4'b0000, 32'h80000020, 32'h0,        32'hCAFEF00D, 5, 7, 0, 0, 0, 15, 0, 0};
    vecs[3] = '{1, 4'b1111, 32'h80000040, 32'hA5A55A5A, 32'h0,        0, 0, 0, 0, 0, 3,  1, 1};
    vecs[4] = '{1, 4'b1000, 32'h80000044, 32'h0BADCAFE, 32'h0,        0, 0, 0, 2, 2, 7,  1, 3};
    vecs[5] = '{0, 4'b0000, 32'hBFC00004, 32'h0,        32'h00000001, 0, 1, 0, 0, 0, 4,  0, 0};

    repeat (2) @(negedge clk);
    chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready, inst_done, data_done}, 7'b0);
    chk("rst_inst_rdata", inst_rdata, 32'h0);
    chk("rst_data_rdata", data_rdata, 32'h0);
    chk("ar_consts", {arlen, arsize, arburst}, {4'd0, 3'b010, 2'b01});
    chk("aw_consts", {awlen, awsize, awburst}, {4'd0, 3'b010, 2'b01});
    rst_n = 1;
    @(negedge clk);

    // Both requesting from reset: data first, then strict alternation.
    cfg_fixed = 0; cfg_ar = 0; cfg_r = 0; cfg_aw = 0; cfg_w = 0; cfg_b = 0;
    inst_addr = 32'h00001000; data_addr = 32'h00002000; data_we = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) push(1, 0, 32'h00002000, 32'h0, 32'h00002000 ^ 32'h5A5A5A5A, 4'h0);
      else            push(0, 0, 32'h00001000, 32'h0, 32'h00001000 ^ 32'h5A5A5A5A, 4'h0);
    end
    inst_req = 1; data_req = 1;
    for (int i = 0; i < 8; i++) begin
      wait_done(lat);
      $display("alt  txn %0d: inst_done=%0b data_done=%0b", i, inst_done, data_done);
    end
    inst_req = 0; data_req = 0;
    @(negedge clk);

    cfg_fixed = 1;
    for (int i = 0; i < 6; i++) begin
      cfg_ar = vecs[i].ar_d; cfg_r = vecs[i].r_d; cfg_aw = vecs[i].aw_d;
      cfg_w = vecs[i].w_d; cfg_b = vecs[i].b_d; cfg_rdata = vecs[i].rdata;
      aw_hi = 0; w_hi = 0;
      push(vecs[i].is_data, vecs[i].we != 4'b0, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].we);
      if (vecs[i].is_data) begin
        data_we = vecs[i].we; data_addr = vecs[i].addr; data_wdata = vecs[i].wdata; data_req = 1;
      end else begin
        inst_addr = vecs[i].addr; inst_req = 1;
      end
      wait_done(lat);
      inst_req = 0; data_req = 0;
      chk("latency", lat, vecs[i].lat);
      chk("awvalid_cycles", aw_hi, vecs[i].exp_aw_hi);
      chk("wvalid_cycles", w_hi, vecs[i].exp_w_hi);
      $display("vec  %0d: addr=%h lat=%0d aw_hi=%0d w_hi=%0d", i, vecs[i].addr, lat, aw_hi, w_hi);
      @(negedge clk);
    end

    // Address change after grant must not reach the bus.
    cfg_ar = 3; cfg_r = 0; cfg_rdata = 32'h00000066;
    push(1, 0, 32'h00000100, 32'h0, 32'h00000066, 4'h0);
    data_we = 4'b0000; data_addr = 32'h00000100; data_req = 1;
    @(negedge clk);
    data_addr = 32'h00000200;
    wait_done(lat);
    data_req = 0;
    $display("late addr change: araddr=%h", obs_araddr);
    @(negedge clk);

    // Asynchronous reset while waiting in RD_DATA.
    cfg_ar = 0; cfg_r = 20;
    inst_addr = 32'h00000300; inst_req = 1;
    begin
      int n = 0;
      while (!rready && n < 20) begin @(negedge clk); n++; end
      chk("reached_rd_data", rready, 1'b1);
    end
    #2 rst_n = 0;
    #1;
    chk("arst_rready", rready, 1'b0);
    chk("arst_done", {inst_done, data_done, arvalid}, 3'b0);
    chk("arst_rdata", inst_rdata | data_rdata, 32'h0);
    $display("async reset: rready=%0b inst_rdata=%h", rready, inst_rdata);
    inst_req = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    cfg_r = 0; cfg_rdata = 32'h00000077;
    push(0, 0, 32'h00000304, 32'h0, 32'h00000077, 4'h0);
    inst_addr = 32'h00000304; inst_req = 1;
    wait_done(lat);
    inst_req = 0;
    chk("post_reset_latency", lat, 3);
    $display("post reset read: inst_rdata=%h lat=%0d", inst_rdata, lat);
    repeat (2) @(negedge clk);

    chk("sb_drained", sb.size(), 0);
    chk("ar_aw_overlap", both_hi, 0);
    chk("ar_stable", ar_unstable, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

endmodule
